// File: rtl/imem_arb_pkg.sv
// Shared defaults, FSM state type and sizing helper for the instruction-memory arbiter.
package imem_arb_pkg;

  localparam int NUM_CORES_DEF = 4;
  localparam int ADDR_W_DEF    = 16;
  localparam int DATA_W_DEF    = 16;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } arb_state_e;

  // Width of a core index; a single-bit minimum keeps degenerate sizes legal.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/imem_arbiter_rr_picker.sv
// Combinational round-robin finder: first requesting core after ptr, wrapping.
module rr_picker
  import imem_arb_pkg::*;
#(
  parameter int N  = NUM_CORES_DEF,
  parameter int IW = idx_bits(NUM_CORES_DEF)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          any
);

  // Walk offsets from farthest to nearest so the closest requester overwrites.
  always_comb begin
    int c;
    c      = 0;
    winner = '0;
    any    = 1'b0;
    for (int i = N; i >= 1; i--) begin
      c = (int'(ptr) + i) % N;
      if (req[c]) begin
        winner = IW'(c);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one instruction memory among NUM_CORES fetch units.
// Optional per-core stall counters when IMEM_ARB_STALL_CNT_EN is defined.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CORES-1:0]          REQ,
  input  logic [NUM_CORES*ADDR_W-1:0]   ADDR,
  output logic [NUM_CORES-1:0]          GNT,
  output logic [NUM_CORES-1:0]          VALID,
  output logic [DATA_W-1:0]             RDATA,
  output logic [ADDR_W-1:0]             MEM_ADDR,
  output logic                          MEM_RD,
  input  logic [DATA_W-1:0]             MEM_DATA
`ifdef IMEM_ARB_STALL_CNT_EN
  , output logic [NUM_CORES*16-1:0]     STALL_CNT
`endif
);

  localparam int IW = idx_bits(NUM_CORES);

  arb_state_e           state_reg, state_next;
  logic [IW-1:0]        ptr_reg, ptr_next;
  logic [NUM_CORES-1:0] gnt_reg, gnt_next;
  logic [NUM_CORES-1:0] valid_reg, valid_next;
  logic [DATA_W-1:0]    rdata_reg, rdata_next;
  logic [ADDR_W-1:0]    mem_addr_reg, mem_addr_next;
  logic                 mem_rd_reg, mem_rd_next;

  logic [NUM_CORES-1:0] busy_mask, eligible, win_onehot;
  logic [ADDR_W-1:0]    addr_arr [NUM_CORES];
  logic [IW-1:0]        winner;
  logic                 any;

  // While a read is outstanding the pointer names its owner; mask it out.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
      assign addr_arr[gi]   = ADDR[gi*ADDR_W +: ADDR_W];
      assign busy_mask[gi]  = (state_reg == READ) && (ptr_reg == IW'(gi));
      assign win_onehot[gi] = any && (winner == IW'(gi));
    end
  endgenerate

  assign eligible = REQ & ~busy_mask;

  rr_picker #(.N(NUM_CORES), .IW(IW)) u_picker (
    .req    (eligible),
    .ptr    (ptr_reg),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    gnt_next      = '0;
    valid_next    = '0;
    rdata_next    = rdata_reg;
    mem_addr_next = mem_addr_reg;
    mem_rd_next   = 1'b0;
    // Memory bus is only meaningful while a read is outstanding.
    if (state_reg == READ) begin
      valid_next = busy_mask;
      rdata_next = MEM_DATA;
    end
    if (any) begin
      gnt_next      = win_onehot;
      mem_rd_next   = 1'b1;
      mem_addr_next = addr_arr[winner];
      ptr_next      = winner;
      state_next    = READ;
    end else begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= IW'(NUM_CORES - 1);
      gnt_reg      <= '0;
      valid_reg    <= '0;
      rdata_reg    <= '0;
      mem_addr_reg <= '0;
      mem_rd_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      gnt_reg      <= gnt_next;
      valid_reg    <= valid_next;
      rdata_reg    <= rdata_next;
      mem_addr_reg <= mem_addr_next;
      mem_rd_reg   <= mem_rd_next;
    end
  end

  assign GNT      = gnt_reg;
  assign VALID    = valid_reg;
  assign RDATA    = rdata_reg;
  assign MEM_ADDR = mem_addr_reg;
  assign MEM_RD   = mem_rd_reg;

`ifdef IMEM_ARB_STALL_CNT_EN
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_stall
      logic [15:0] cnt_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          cnt_reg <= '0;
        else if (REQ[gi] && !win_onehot[gi] && (cnt_reg != 16'hFFFF))
          cnt_reg <= cnt_reg + 16'd1;
      end
      assign STALL_CNT[gi*16 +: 16] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus randomized traffic
// against a behavioural arbitration model (stall counters when IMEM_ARB_STALL_CNT_EN).
module tb_imem_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr;
  logic [N-1:0]    gnt, valid;
  logic [DW-1:0]   rdata, mem_data;
  logic [AW-1:0]   mem_addr;
  logic            mem_rd;
`ifdef IMEM_ARB_STALL_CNT_EN
  logic [N*16-1:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit quiet    = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0010) return 16'hBEEF;
    return (a ^ 16'hA5C3) + {a[12:0], 3'b000};
  endfunction

  // Undriven bus is modelled as junk so any capture outside READ shows up.
  assign mem_data = mem_rd ? mem_word(mem_addr) : 16'hDEAD;

  imem_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .REQ      (req),
    .ADDR     (addr),
    .GNT      (gnt),
    .VALID    (valid),
    .RDATA    (rdata),
    .MEM_ADDR (mem_addr),
    .MEM_RD   (mem_rd),
    .MEM_DATA (mem_data)
`ifdef IMEM_ARB_STALL_CNT_EN
    , .STALL_CNT(stall_cnt)
`endif
  );

  // Reference model state
  int            m_ptr, m_owner;
  logic [15:0]   m_addr;
  logic [N-1:0]  exp_gnt, exp_valid;
  logic [DW-1:0] exp_rdata;
  logic [AW-1:0] exp_mem_addr;
  logic          exp_mem_rd;
  int unsigned   m_stall [N];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr        = N - 1;
    m_owner      = -1;
    m_addr       = '0;
    exp_gnt      = '0;
    exp_valid    = '0;
    exp_rdata    = '0;
    exp_mem_addr = '0;
    exp_mem_rd   = 1'b0;
    for (int i = 0; i < N; i++) m_stall[i] = 0;
  endtask

  // One clock edge of the arbitration rules, using the inputs seen at that edge.
  task automatic model_step();
    int w;
    w = -1;
    exp_valid = '0;
    if (m_owner >= 0) begin
      exp_valid[m_owner] = 1'b1;
      exp_rdata          = mem_word(m_addr);
    end
    for (int i = 1; i <= N; i++) begin
      int c;
      c = (m_ptr + i) % N;
      if (w < 0 && req[c] && c != m_owner) w = c;
    end
    for (int c = 0; c < N; c++)
      if (req[c] && c != w && m_stall[c] < 65535) m_stall[c]++;
    exp_gnt = '0;
    if (w >= 0) begin
      exp_gnt[w]   = 1'b1;
      exp_mem_rd   = 1'b1;
      exp_mem_addr = addr[w*AW +: AW];
      m_ptr        = w;
      m_owner      = w;
      m_addr       = exp_mem_addr;
    end else begin
      exp_mem_rd = 1'b0;
      m_owner    = -1;
    end
  endtask

  task automatic compare_all();
`ifdef IMEM_ARB_STALL_CNT_EN
    logic [N*16-1:0] exp_stall;
    for (int i = 0; i < N; i++) exp_stall[i*16 +: 16] = 16'(m_stall[i]);
    check_val("stall_cnt", stall_cnt, exp_stall);
`endif
    check_val("gnt", gnt, exp_gnt);
    check_val("valid", valid, exp_valid);
    check_val("rdata", rdata, exp_rdata);
    check_val("mem_rd", mem_rd, exp_mem_rd);
    check_val("mem_addr", mem_addr, exp_mem_addr);
    if (!quiet && valid != '0)
      $display("txn: valid=%b rdata=%h gnt=%b", valid, rdata, gnt);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    compare_all();
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_addr(input int core, input logic [15:0] a);
    addr[core*AW +: AW] = a;
  endtask

  initial begin
    logic [N-1:0] e;
    logic         seen1;
    int           seq4 [4];
    req   = '0;
    addr  = '0;
    rst_n = 1'b1;
    #2;
    do_reset();

    // Reset in the middle of a read: no VALID afterwards, core 0 first.
    req = 4'b0001;
    set_addr(0, 16'h0020);
    tick();
    check_val("t1_gnt", gnt, 4'b0001);
    check_val("t1_rd", mem_rd, 1'b1);
    do_reset();
    check_val("t1_gnt_rst", gnt, 4'b0000);
    check_val("t1_rd_rst", mem_rd, 1'b0);
    req = '0;
    tick();
    check_val("t1_no_valid", valid, 4'b0000);
    req = 4'b1111;
    tick();
    check_val("t1_first", gnt, 4'b0001);

    // Single requester: one fetch every two cycles.
    req = '0;
    do_reset();
    req = 4'b0100;
    set_addr(2, 16'h0010);
    tick();
    check_val("t2_gnt", gnt, 4'b0100);
    tick();
    check_val("t2_valid", valid, 4'b0100);
    check_val("t2_rdata", rdata, 16'hBEEF);
    check_val("t2_gnt_gap", gnt, 4'b0000);
    tick();
    check_val("t2_gnt2", gnt, 4'b0100);

    // Full contention: strict rotation, VALID one cycle behind GNT.
    req = '0;
    do_reset();
    for (int i = 0; i < N; i++) set_addr(i, 16'h0100 + 16'(i));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      e = 4'b0001 << (k % 4);
      check_val("t3_gnt", gnt, e);
      if (k > 0) begin
        e = 4'b0001 << ((k - 1) % 4);
        check_val("t3_valid", valid, e);
        check_val("t3_rdata", rdata, mem_word(16'h0100 + 16'((k - 1) % 4)));
      end
    end

    // Wrap from pointer 3: cores 0 and 3 alternate.
    req = '0;
    do_reset();
    req = 4'b1001;
    seq4 = '{0, 3, 0, 3};
    for (int k = 0; k < 4; k++) begin
      tick();
      e = 4'b0001 << seq4[k];
      check_val("t4_gnt", gnt, e);
    end

    // Withdraw before grant vs. drop after grant.
    req = '0;
    do_reset();
    seen1 = 1'b0;
    req = 4'b0100;
    set_addr(2, 16'h0042);
    set_addr(3, 16'h0043);
    tick();
    check_val("t5_gnt2", gnt, 4'b0100);
    req = 4'b1010;
    tick();
    seen1 |= gnt[1];
    check_val("t5_gnt3", gnt, 4'b1000);
    check_val("t5_valid2", valid, 4'b0100);
    req = 4'b0000;
    tick();
    seen1 |= gnt[1];
    check_val("t5_valid3", valid, 4'b1000);
    check_val("t5_rdata3", rdata, mem_word(16'h0043));
    tick();
    seen1 |= gnt[1];
    check_val("t5_core1_never", seen1, 1'b0);

`ifdef IMEM_ARB_STALL_CNT_EN
    do_reset();
    req = 4'b0011;
    for (int k = 0; k < 10; k++) tick();
    check_val("t6_stall10", stall_cnt, 64'h0000_0000_0005_0005);
    quiet = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 88000; k++) tick();
    quiet = 1'b0;
    check_val("t6_sat", stall_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    req = '0;
`endif

    // Randomized traffic against the model, with occasional async resets.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(3) == 0) addr = {$urandom, $urandom};
      for (int i = 0; i < N; i++) req[i] = ($urandom_range(9) < 6);
      if ($urandom_range(199) == 0) do_reset();
      else tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
